// File: rtl/control_display.sv
// ============================================================================
// Module   : control_display
// Purpose  : 4-digit multiplexed 7-segment scan controller. Each digit is
//            driven for REFRESH_DIV cycles, then all anodes are off for
//            BLANK_CYCLES cycles. New data is applied only at frame boundaries.
// Options  : LEADING_ZERO_BLANK_EN -- blank leading zero digits 3..1
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_display #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] digitos,
  input  logic        cargar,
  output logic [4:0]  code_sel,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        frame_start
);

  localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT);
  localparam logic [CNT_W-1:0] ACT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [4:0]       CODE_BLANK = 5'b11111;

  localparam logic [0:0] S_BLANK  = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0][4:0]  frame_q, frame_d;
  logic [3:0][4:0]  pending_q, pending_d;
  logic             pend_q, pend_d;
  logic             enter_act;
  logic [4:0]       code_sel_q, code_sel_d;
  logic [3:0]       an_q, an_d;
  logic             frame_start_q, frame_start_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_BLANK;
      cnt_q         <= '0;
      idx_q         <= 2'd3;
      frame_q       <= {4{CODE_BLANK}};
      pending_q     <= {4{CODE_BLANK}};
      pend_q        <= 1'b0;
      code_sel_q    <= CODE_BLANK;
      an_q          <= 4'b1111;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      frame_q       <= frame_d;
      pending_q     <= pending_d;
      pend_q        <= pend_d;
      code_sel_q    <= code_sel_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    frame_d   = frame_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    enter_act = 1'b0;
    case (state_q)
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d   = S_ACTIVE;
          cnt_d     = '0;
          idx_d     = idx_q + 2'd1;
          enter_act = 1'b1;
        end
      end
      default: begin
        if (cnt_q == ACT_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
        end
      end
    endcase
    // Frame swap uses the old pending copy; a coincident strobe waits a frame.
    if (enter_act && (idx_d == 2'd0) && pend_q) begin
      frame_d = pending_q;
      pend_d  = 1'b0;
    end
    if (cargar) begin
      pending_d = digitos;
      pend_d    = 1'b1;
    end
  end

  always_comb begin
    logic [4:0] code;
    logic [3:0] lz_blank;
    an_d          = 4'b1111;
    code_sel_d    = CODE_BLANK;
    frame_start_d = 1'b0;
    code          = frame_d[idx_d];
    lz_blank      = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    lz_blank[3] = (frame_d[3] == 5'd0);
    lz_blank[2] = lz_blank[3] && (frame_d[2] == 5'd0);
    lz_blank[1] = lz_blank[2] && (frame_d[1] == 5'd0);
`endif
    if (state_d == S_ACTIVE) begin
      an_d          = ~(4'b0001 << idx_d);
      code_sel_d    = ((code > 5'd16) || lz_blank[idx_d]) ? CODE_BLANK : code;
      frame_start_d = enter_act && (idx_d == 2'd0);
    end
  end

  assign code_sel    = code_sel_q;
  assign an          = an_q;
  assign digit_idx   = idx_q;
  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_control_display.sv
// ============================================================================
// Module   : tb_control_display
// Purpose  : Self-checking bench for control_display using a cycle-position
//            reference model (REFRESH_DIV=4, BLANK_CYCLES=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_display;

  localparam int RD    = 4;
  localparam int BC    = 2;
  localparam int DIGP  = RD + BC;
  localparam int FRMP  = 4 * DIGP;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] digitos;
  logic        cargar;
  logic [4:0]  code_sel;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_start;

  int n_checks = 0;
  int n_errors = 0;

  // Model: n counts edges since the last reset edge; everything derives from it.
  int         n = 0;
  logic [4:0] m_frame [4];
  logic [4:0] m_pending [4];
  bit         m_pend = 1'b0;

  control_display #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digitos    (digitos),
    .cargar     (cargar),
    .code_sel   (code_sel),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (n=%0d, t=%0t)", tag, obs, exp, n, $time);
    end
  endtask

  function automatic logic [4:0] exp_code(input int d);
    logic [4:0] c;
    bit all_zero;
    c = m_frame[d];
    if (c > 5'd16) c = 5'b11111;
    all_zero = 1'b1;
    for (int j = 3; j >= d; j--) if (m_frame[j] != 5'd0) all_zero = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && all_zero) c = 5'b11111;
`endif
    return c;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      n = 0;
      m_pend = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_frame[i]   = 5'b11111;
        m_pending[i] = 5'b11111;
      end
    end else begin
      n++;
      if ((n % FRMP) == BC && m_pend) begin
        for (int i = 0; i < 4; i++) m_frame[i] = m_pending[i];
        m_pend = 1'b0;
      end
      if (cargar) begin
        for (int i = 0; i < 4; i++) m_pending[i] = digitos[i*5 +: 5];
        m_pend = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    int ph, d, e_idx;
    bit act;
    logic [3:0] e_an;
    logic [4:0] e_code;
    ph  = n % DIGP;
    d   = (n / DIGP) % 4;
    act = (ph >= BC);
    e_an   = act ? ~(4'b0001 << d) : 4'b1111;
    e_idx  = act ? d : (d + 3) % 4;
    e_code = act ? exp_code(d) : 5'b11111;
    check("an", int'(an), int'(e_an));
    check("digit_idx", int'(digit_idx), e_idx);
    check("code_sel", int'(code_sel), int'(e_code));
    check("frame_start", int'(frame_start), ((n % FRMP) == BC) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic load(input logic [19:0] val);
    digitos = val;
    cargar  = 1'b1;
    tick();
    cargar  = 1'b0;
  endtask

  // Advance so that the next edge lands on frame position pos.
  task automatic align_next(input int pos);
    for (int i = 0; i < FRMP && ((n + 1) % FRMP) != pos; i++) tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    cargar  = 1'b0;
    digitos = '0;
    run(3);
    rst_n = 1'b1;
    run(30);

    align_next(10);
    load({5'd16, 5'd10, 5'd3, 5'd0});
    run(50);

    align_next(5);
    load({5'd1, 5'd2, 5'd3, 5'd4});
    run(4);
    load({5'd9, 5'd8, 5'd7, 5'd6});
    run(30);

    align_next(BC);
    load({5'd15, 5'd14, 5'd13, 5'd12});
    run(50);

    align_next(7);
    load({5'd5, 5'd20, 5'd31, 5'd17});
    run(30);

    align_next(9);
    load({5'd0, 5'd0, 5'd7, 5'd0});
    run(30);

    align_next(12);
    load({5'd11, 5'd11, 5'd11, 5'd11});
    align_next(15);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run(50);

    for (int i = 0; i < 2500; i++) begin
      digitos = '0;
      for (int k = 0; k < 4; k++)
        digitos[k*5 +: 5] = ($urandom_range(1, 0) == 1) ? 5'd0 : 5'($urandom_range(31, 0));
      cargar = ($urandom_range(19, 0) == 0);
      rst_n  = ($urandom_range(499, 0) != 0);
      tick();
    end
    cargar = 1'b0;
    rst_n  = 1'b1;
    run(30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/control_display.md
CONTROL_DISPLAY -- requirements
Module: control_display

Parameters
REQ-001 The module SHALL have parameter REFRESH_DIV, default 50000, meaning clock cycles each digit is driven (ACTIVE state); legal range 2..2^20.
REQ-002 The module SHALL have parameter BLANK_CYCLES, default 500, meaning clock cycles all anodes are off between digits (BLANK state); legal range 1..2^16.

Interface
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 digitos  input  20  four 5-bit digit codes; [4:0]=digit0 (least significant) .. [19:15]=digit3; codes 0-15 = hex, 16 = double-error, 17-31 = blank.
REQ-006 cargar  input  1  one-cycle strobe; captures digitos into the pending buffer.
REQ-007 code_sel  output  5  code for the shared 7-segment decoder; 5'b11111 = blank.
REQ-008 an  output  4  anode enables, active-low, one-hot-low when active; an[i] selects digit i.
REQ-009 digit_idx  output  2  index of the digit currently scanned.
REQ-010 frame_start  output  1  one-cycle pulse on entry to ACTIVE for digit 0.

Function
REQ-011 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-012 FSM states: BLANK, ACTIVE; a single down/up counter times both states.
REQ-013 BLANK: an=4'b1111, code_sel=5'b11111; lasts exactly BLANK_CYCLES cycles, then ACTIVE.
REQ-014 ACTIVE: an[digit_idx]=0, others 1; code_sel=frame[digit_idx]; lasts exactly REFRESH_DIV cycles, then BLANK.
REQ-015 digit_idx SHALL increment modulo 4 on each BLANK->ACTIVE transition (3 wraps to 0).
REQ-016 Digit period = REFRESH_DIV+BLANK_CYCLES cycles; frame period = 4x that.
REQ-017 cargar=1 SHALL copy digitos into pending and set pend flag on the same edge; a later cargar before the frame boundary overwrites pending (last wins).
REQ-018 On BLANK->ACTIVE with next digit_idx=0, if pend set: frame<=pending, pend cleared; displayed data changes only at frame boundaries (no tearing).
REQ-019 cargar on the same edge as the frame boundary SHALL be captured into pending and applied at the following frame boundary; the boundary uses the previous pending content.
REQ-020 frame_start SHALL assert for exactly the first ACTIVE cycle of digit 0.
REQ-021 code_sel SHALL pass codes 0-16 unchanged and SHALL force codes 17-31 to 5'b11111.

Reset
REQ-022 While rst_n=0 at a clock edge: state=BLANK, counter=0, digit_idx=3, an=4'b1111, code_sel=5'b11111, frame_start=0, frame all 5'b11111, pending all 5'b11111, pend=0.
REQ-023 After release, first ACTIVE SHALL be digit 0 after BLANK_CYCLES cycles, with frame_start=1.
REQ-024 Reset asserted mid-ACTIVE SHALL blank anodes on the next edge and discard pending data.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN defined: digit i (i=3..1) whose code is 0 and all higher digits are 0 SHALL output code_sel=5'b11111 (anode still driven); digit0 never suppressed; evaluated on frame content.
REQ-026 Macro undefined: all digits displayed as stored; no suppression logic compiled.

Verification (bench uses REFRESH_DIV=4, BLANK_CYCLES=2)
REQ-027 Reset release, no cargar -> an=1111 for 2 cycles, then an=1110/code_sel=11111 for 4 cycles, frame_start pulse; sequence 1110,1101,1011,0111 each separated by 2 blank cycles, period 24.
REQ-028 cargar with digitos={5'd16,5'd10,5'd3,5'd0} mid-frame -> no change until next frame_start; then code_sel 0,3,10,16 on digits 0..3.
REQ-029 Two cargar strobes in one frame (values A then B) -> next frame shows B only; cargar coincident with frame_start -> applied one frame later.
REQ-030 Digit code 5'd20 -> code_sel=5'b11111 while its anode is low.
REQ-031 With LEADING_ZERO_BLANK_EN, digitos={0,0,5'd7,0} -> digits 3,2 blank, digit1=7, digit0=0; without macro -> 0,0,7,0.
REQ-032 rst_n=0 during ACTIVE of digit 2 with pend set -> next edge an=1111; after release digit 0 shows blank, pending discarded.
